// File: rtl/bargraph_peak.sv
// LED bar-graph driver: thermometer level from the highest set data bit,
// bar or dot display, with an optional peak marker that holds and then decays.
module bargraph_peak #(
  parameter int unsigned N_LEDS       = 8,
  parameter int unsigned HOLD_CYCLES  = 50000000,
  parameter int unsigned DECAY_CYCLES = 5000000,
  localparam int unsigned LW          = $clog2(N_LEDS + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_LEDS-1:0] data,
  input  logic              sample_en,
  input  logic [1:0]        mode,
  input  logic              clear_peak,
  output logic [N_LEDS-1:0] leds,
  output logic [LW-1:0]     level,
  output logic [LW-1:0]     peak_level
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned DW = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DECAY = 2'd2;

  logic [1:0]        state, state_next;
  logic [LW-1:0]     level_next, peak_next, decay_val;
  logic [HW-1:0]     hold_cnt, hold_next;
  logic [DW-1:0]     decay_cnt, decay_next;
  logic [N_LEDS-1:0] leds_next;

  // Priority encoder: highest set bit index plus one, zero for an empty word
  always_comb begin
    level_next = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      if (data[i]) level_next = LW'(i + 1);
    end
  end

  // One-LED decay step, floored at the current level
  always_comb begin
    decay_val = level;
    if ((peak_level != '0) && ((peak_level - LW'(1)) > level)) decay_val = peak_level - LW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    peak_next  = peak_level;
    hold_next  = hold_cnt;
    decay_next = decay_cnt;
    if (clear_peak) begin
      state_next = IDLE;
      peak_next  = '0;
      hold_next  = '0;
      decay_next = '0;
    end else begin
      case (state)
        IDLE: begin
          peak_next = '0;
          if (level != '0) begin
            peak_next  = level;
            state_next = HOLD;
            hold_next  = '0;
          end
        end
        HOLD: begin
          if (level > peak_level) begin
            peak_next = level;
            hold_next = '0;
          end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            state_next = DECAY;
            hold_next  = '0;
            decay_next = '0;
          end else begin
            hold_next = hold_cnt + HW'(1);
          end
        end
        DECAY: begin
          if (level > peak_level) begin
            peak_next  = level;
            state_next = HOLD;
            hold_next  = '0;
          end else if (decay_cnt == DW'(DECAY_CYCLES - 1)) begin
            decay_next = '0;
            peak_next  = decay_val;
            if (decay_val == '0) state_next = IDLE;
          end else begin
            decay_next = decay_cnt + DW'(1);
          end
        end
        default: begin
          state_next = IDLE;
          peak_next  = '0;
          hold_next  = '0;
          decay_next = '0;
        end
      endcase
    end
  end

  // mode[0] selects dot over bar, mode[1] overlays the peak marker
  always_comb begin
    leds_next = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      leds_next[i] = mode[0] ? (LW'(i + 1) == level) : (LW'(i) < level);
      if (mode[1] && (LW'(i + 1) == peak_level)) leds_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      level      <= '0;
      peak_level <= '0;
      leds       <= '0;
      hold_cnt   <= '0;
      decay_cnt  <= '0;
    end else begin
      if (sample_en) level <= level_next;
      peak_level <= peak_next;
      leds       <= leds_next;
      hold_cnt   <= hold_next;
      decay_cnt  <= decay_next;
    end
  end

endmodule

// File: tb/tb_bargraph_peak.sv
// Scoreboard bench for bargraph_peak: directed per-edge vectors with
// hand-derived expected level, peak and LED patterns.
module tb_bargraph_peak;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] data;
  logic       sample_en;
  logic [1:0] mode;
  logic       clear_peak;
  logic [7:0] leds;
  logic [3:0] level;
  logic [3:0] peak_level;

  always #5 clock = ~clock;

  bargraph_peak #(.N_LEDS(8), .HOLD_CYCLES(4), .DECAY_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .data(data), .sample_en(sample_en),
    .mode(mode), .clear_peak(clear_peak), .leds(leds), .level(level),
    .peak_level(peak_level)
  );

  typedef struct {
    logic       rst_n;
    logic [7:0] data;
    logic       se;
    logic [1:0] mode;
    logic       clr;
    logic [3:0] lvl;
    logic [3:0] pk;
    logic [7:0] leds;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] lvl;
    logic [3:0] pk;
    logic [7:0] leds;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic add(input int r, input int d, input int s, input int m, input int c,
                     input int l, input int p, input int ld);
    vec_t v;
    v.rst_n = 1'(r);  v.data = 8'(d); v.se = 1'(s); v.mode = 2'(m); v.clr = 1'(c);
    v.lvl = 4'(l);    v.pk = 4'(p);   v.leds = 8'(ld);
    vecs.push_back(v);
  endtask

  task automatic rst();
    add(0, 0, 0, 0, 0, 0, 0, 'h00);
  endtask

  // Decay from peak 8 toward level 3 in bar+peak mode, up to peak 6
  task automatic decay_prefix();
    rst();
    add(1, 'h80, 1, 2, 0, 8, 0, 'h00);
    add(1, 'h04, 1, 2, 0, 3, 8, 'hFF);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 2, 0, 3, 8, 'h87);
    add(1, 0, 0, 2, 0, 3, 7, 'h87);
    add(1, 0, 0, 2, 0, 3, 7, 'h47);
    add(1, 0, 0, 2, 0, 3, 6, 'h47);
  endtask

  task automatic build();
    // reset overrides capture, then release
    add(0, 'hFF, 1, 0, 0, 0, 0, 'h00);
    add(0, 'hFF, 1, 0, 0, 0, 0, 'h00);
    add(1, 'hFF, 1, 0, 0, 8, 0, 'h00);
    add(1, 'hFF, 0, 0, 0, 8, 8, 'hFF);
    // bar and dot encoding
    rst();
    add(1, 'h16, 1, 0, 0, 5, 0, 'h00);
    add(1, 'h16, 0, 0, 0, 5, 5, 'h1F);
    add(1, 0, 0, 1, 0, 5, 5, 'h10);
    add(1, 0, 1, 1, 0, 0, 5, 'h10);
    add(1, 0, 0, 1, 0, 0, 5, 'h00);
    add(1, 0, 0, 0, 0, 0, 5, 'h00);
    // hold, decay to steady level, then decay to zero
    decay_prefix();
    add(1, 0, 0, 2, 0, 3, 6, 'h27);
    add(1, 0, 0, 2, 0, 3, 5, 'h27);
    add(1, 0, 0, 2, 0, 3, 5, 'h17);
    add(1, 0, 0, 2, 0, 3, 4, 'h17);
    add(1, 0, 0, 2, 0, 3, 4, 'h0F);
    add(1, 0, 0, 2, 0, 3, 3, 'h0F);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 2, 0, 3, 3, 'h07);
    add(1, 0, 1, 2, 0, 0, 3, 'h07);
    add(1, 0, 0, 2, 0, 0, 3, 'h04);
    add(1, 0, 0, 2, 0, 0, 2, 'h04);
    add(1, 0, 0, 2, 0, 0, 2, 'h02);
    add(1, 0, 0, 2, 0, 0, 1, 'h02);
    add(1, 0, 0, 2, 0, 0, 1, 'h01);
    add(1, 0, 0, 2, 0, 0, 0, 'h01);
    add(1, 0, 0, 2, 0, 0, 0, 'h00);
    // recapture during decay restarts the hold
    decay_prefix();
    add(1, 'h40, 1, 2, 0, 7, 6, 'h27);
    add(1, 'h04, 1, 2, 0, 3, 7, 'h7F);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 2, 0, 3, 7, 'h47);
    add(1, 0, 0, 2, 0, 3, 6, 'h47);
    add(1, 0, 0, 2, 0, 3, 6, 'h27);
    // clear_peak pulses
    rst();
    add(1, 'h80, 1, 2, 0, 8, 0, 'h00);
    add(1, 'h10, 1, 2, 0, 5, 8, 'hFF);
    add(1, 0, 0, 2, 1, 5, 0, 'h9F);
    add(1, 0, 0, 2, 0, 5, 5, 'h1F);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 2, 0, 5, 5, 'h1F);
    add(1, 0, 0, 2, 1, 5, 0, 'h1F);
    add(1, 0, 0, 2, 0, 5, 5, 'h1F);
    // dot+peak, then mode change mid-hold
    rst();
    add(1, 'h20, 1, 3, 0, 6, 0, 'h00);
    add(1, 'h02, 1, 3, 0, 2, 6, 'h20);
    add(1, 0, 0, 3, 0, 2, 6, 'h22);
    add(1, 0, 0, 0, 0, 2, 6, 'h03);
    add(1, 0, 0, 0, 0, 2, 6, 'h03);
  endtask

  // Monitor: every edge that has a pending expectation is checked
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (level === e.lvl && peak_level === e.pk && leds === e.leds) passed++;
      else $display("FAIL row%0d: level=%0d peak=%0d leds=%h, required level=%0d peak=%0d leds=%h",
                    e.idx, level, peak_level, leds, e.lvl, e.pk, e.leds);
    end
  end

  initial begin
    exp_t e;
    reset_n = 1'b0; data = '0; sample_en = 1'b0; mode = 2'b00; clear_peak = 1'b0;
    build();
    foreach (vecs[k]) begin
      @(negedge clock);
      reset_n = vecs[k].rst_n; data = vecs[k].data; sample_en = vecs[k].se;
      mode = vecs[k].mode; clear_peak = vecs[k].clr;
      e.idx = k; e.lvl = vecs[k].lvl; e.pk = vecs[k].pk; e.leds = vecs[k].leds;
      sb.push_back(e);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL drain: %0d expectations left, required 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
